mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Sits between the pipeline stages and the memory.
//  Serialises requests, sequences each access with a ready handshake and returns a one-cycle ack.
//  Drives stall_if and stall_mem so the pipeline holds while a requester waits.
// PARAMETERS
//  ADDR_W       32   address width
//  DATA_W       32   data width; byte mask width is DATA_W/8
//  TIMEOUT_CYC  255  max BUSY cycles without mem_ready before abort; 0 disables the watchdog
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  if_req     in   1         fetch request; held with if_addr until if_ack
//  if_addr    in   ADDR_W    fetch address
//  if_rdata   out  DATA_W    fetch data; valid while if_ack=1
//  if_ack     out  1         one-cycle fetch completion pulse
//  dm_req     in   1         data request; held with its fields until dm_ack
//  dm_we      in   1         1=store, 0=load
//  dm_addr    in   ADDR_W    data address
//  dm_wdata   in   DATA_W    store data
//  dm_wmask   in   DATA_W/8  store byte enables
//  dm_rdata   out  DATA_W    load data; valid while dm_ack=1
//  dm_ack     out  1         one-cycle data completion pulse
//  mem_req    out  1         memory access strobe
//  mem_we     out  1         memory write enable
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_wmask  out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data; sampled when mem_ready=1
//  mem_ready  in   1         memory completes the current access
//  stall_if   out  1         if_req & ~if_ack (combinational)
//  stall_mem  out  1         dm_req & ~dm_ack (combinational)
//  err        out  1         sticky watchdog-timeout flag
// BEHAVIOUR
//  - FSM states and transitions:
//    - IDLE -> BUSY_IF or BUSY_DM when a request is present.
//    - BUSY_* -> RESP_IF or RESP_DM on mem_ready or on timeout.
//    - RESP_* -> IDLE after one cycle.
//  - Grant in IDLE:
//    - The winner's addr, we, wdata and wmask are latched into registers.
//    - mem_* outputs drive from those registers only while in BUSY_*.
//    - Outside BUSY_*, every mem_* output is 0.
//  - Fetch accesses drive mem_we=0 and mem_wmask=0.
//  - Loads drive mem_wmask=0.
//  - In BUSY_*, mem_req=1 every cycle until mem_ready.
//    - On mem_ready, mem_rdata is captured into the read-data register.
//    - The watchdog counter clears.
//  - RESP_*: the matching ack=1 for exactly one cycle; *_rdata = captured data.
//    - The other ack stays 0.
//    - Stores return rdata=0.
//  - No grant is issued in RESP_*; the requester drops req on the cycle after ack.
//  - Latency from req seen in IDLE to ack = 2 + (cycles mem_ready is late).
//    - Minimum throughput is one access per 3 cycles.
//  - Watchdog (TIMEOUT_CYC != 0):
//    - The counter increments each BUSY cycle without mem_ready.
//    - On the TIMEOUT_CYC-th such cycle: go to RESP_*, deliver rdata=0, set err=1.
//    - err stays 1 until rst.
//  - If req drops mid-BUSY (illegal), the access still completes and ack still pulses.
//  - rst asserted at any time, asynchronously:
//    - state=IDLE; mem_*, acks, rdata, err and the counter go to 0; last_grant=IF.
//    - An in-flight access is abandoned with no ack.
//  - Arithmetic: the counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates.
// CONFIGURATION
//  MEM_ARB_FAIR_EN defined:
//    - Round-robin between the two requesters.
//    - A last_grant bit updates on every grant.
//    - When both request in IDLE, the requester not granted last wins.
//  MEM_ARB_FAIR_EN undefined:
//    - Fixed priority: dm_req beats if_req (older instruction first).
//    - No last_grant state is kept.
// TESTING
//  1. if_req=1 with addr 0x0000_0040 at cycle 0; mem_ready=1 at cycle 1 with rdata 0x0000_0013
//     -> mem_req=1 at cycle 1; if_ack=1 and if_rdata=0x0000_0013 at cycle 2; stall_if=1 at cycles 0-1.
//  2. if_req and dm_req both rise at cycle 0; mem_ready is immediate
//     -> without the macro: dm_ack at cycle 2, if_ack at cycle 5.
//     -> with MEM_ARB_FAIR_EN after a prior DM grant: if_ack at cycle 2, dm_ack at cycle 5.
//  3. Store with addr 0x100, wdata 0xDEADBEEF, wmask 0xF
//     -> during BUSY: mem_we=1 and mem_addr, mem_wdata, mem_wmask match the request.
//     -> a single dm_ack with dm_rdata=0.
//  4. mem_ready arrives 5 cycles late (cycle 6)
//     -> mem_req high for cycles 1-6; if_ack only at cycle 7; stall_if=1 for cycles 0-6.
//  5. TIMEOUT_CYC=16 and mem_ready never asserted
//     -> BUSY for cycles 1-16; ack with rdata=0 at cycle 17; err=1 from cycle 17 until rst.
//  6. rst pulsed at cycle 3 of a BUSY_DM access
//     -> mem_req, dm_ack and err read 0 immediately; state IDLE; the next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF) and load/store (DM).
// Latency: request seen in IDLE -> ack two cycles later plus memory wait cycles; at most one access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; stall_if/stall_mem hold the pipeline meanwhile.
// Build option: define MEM_ARB_FAIR_EN for round-robin arbitration; default is fixed priority (DM beats IF).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  // data (load/store) port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  // pipeline control / status
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  localparam int MASK_W = DATA_W / 8;
  localparam bit WD_EN  = (TIMEOUT_CYC != 0);
  // Counter holds values 0..TIMEOUT_CYC; keep at least one bit when the watchdog is off.
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Count value seen on the last allowed wait cycle: that cycle's miss is the TIMEOUT_CYC-th.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_DM = 3'd2,
    S_RESP_IF = 3'd3,
    S_RESP_DM = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                mem_req_q;
  logic                if_ack_q;
  logic                dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    wd_cnt_q;
  logic [CNT_W-1:0]    wd_cnt_d;
  logic                wd_expire;
  logic                grant_dm;
`ifdef MEM_ARB_FAIR_EN
  // 1 = the data port won the most recent grant, 0 = fetch did
  logic                last_grant_q;
`endif

  // Arbitration: decide which requester wins if a grant is issued this cycle.
  always_comb begin
    grant_dm = dm_req;
`ifdef MEM_ARB_FAIR_EN
    if (dm_req && if_req) begin
      grant_dm = ~last_grant_q;
    end
`endif
  end

  // Watchdog: saturating next count and the abort condition for the current wait cycle.
  always_comb begin
    wd_cnt_d  = (wd_cnt_q == CNT_SAT) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
    wd_expire = WD_EN && !mem_ready && (wd_cnt_q == CNT_LAST);
  end

  // Access sequencer: grant, memory handshake, one-cycle response, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      mem_req_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
      wd_cnt_q   <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_req || dm_req) begin
            mem_req_q <= 1'b1;
            wd_cnt_q  <= '0;
            if (grant_dm) begin
              state_q <= S_BUSY_DM;
              addr_q  <= dm_addr;
              we_q    <= dm_we;
              wdata_q <= dm_wdata;
              // loads never enable byte lanes
              wmask_q <= dm_we ? dm_wmask : '0;
`ifdef MEM_ARB_FAIR_EN
              last_grant_q <= 1'b1;
`endif
            end else begin
              state_q <= S_BUSY_IF;
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
`ifdef MEM_ARB_FAIR_EN
              last_grant_q <= 1'b0;
`endif
            end
          end
        end

        S_BUSY_IF, S_BUSY_DM: begin
          // The requester's req is not consulted here: an access once granted always completes.
          if (mem_ready || wd_expire) begin
            mem_req_q <= 1'b0;
            wd_cnt_q  <= '0;
            if (state_q == S_BUSY_IF) begin
              state_q    <= S_RESP_IF;
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              state_q    <= S_RESP_DM;
              dm_ack_q   <= 1'b1;
              // stores and aborted accesses return zero data
              dm_rdata_q <= (mem_ready && !we_q) ? mem_rdata : '0;
            end
            if (wd_expire) begin
              err_q <= 1'b1;
            end
          end else if (WD_EN) begin
            wd_cnt_q <= wd_cnt_d;
          end
        end

        S_RESP_IF, S_RESP_DM: begin
          // No grant here: the acked requester only drops req next cycle.
          state_q    <= S_IDLE;
          if_ack_q   <= 1'b0;
          dm_ack_q   <= 1'b0;
          if_rdata_q <= '0;
          dm_rdata_q <= '0;
        end

        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          if_ack_q  <= 1'b0;
          dm_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  // mem_req_q is high exactly while an access is in BUSY, so it gates the latched fields.
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q & we_q;
  assign mem_addr  = mem_req_q ? addr_q  : '0;
  assign mem_wdata = mem_req_q ? wdata_q : '0;
  assign mem_wmask = mem_req_q ? wmask_q : '0;

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;

  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 16;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [MW-1:0] dm_wmask;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic          if_ack, dm_ack, mem_req, mem_we, stall_if, stall_mem, err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // who: 0 = nobody, 1 = fetch, 2 = data
  int            m_inflight;   // access currently occupying the memory
  int            m_wait;       // memory cycles that access has waited so far
  int            m_acking;     // port receiving its completion this cycle
  int            m_last;       // port granted most recently (1 = fetch, 2 = data)
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  logic          m_we;
  logic          m_err;

  task automatic model_reset();
    m_inflight = 0; m_wait = 0; m_acking = 0; m_last = 1;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_we = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs of the cycle just observed.
  task automatic model_step();
    int who;
    if (m_inflight != 0) begin
      if (mem_ready) begin
        m_acking = m_inflight;
        m_rdata  = (m_inflight == 2 && m_we) ? '0 : mem_rdata;
        m_inflight = 0;
      end else if (m_wait + 1 == TO) begin
        m_acking = m_inflight;
        m_rdata  = '0;
        m_err    = 1'b1;
        m_inflight = 0;
      end else begin
        m_wait++;
      end
    end else if (m_acking != 0) begin
      m_acking = 0;              // response cycle is followed by one idle cycle
    end else if (if_req || dm_req) begin
      if (if_req && dm_req) who = FAIR ? ((m_last == 2) ? 1 : 2) : 2;
      else                  who = dm_req ? 2 : 1;
      m_inflight = who;
      m_last     = who;
      m_wait     = 0;
      if (who == 2) begin
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        m_wmask = dm_we ? dm_wmask : '0;
      end else begin
        m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_wmask = '0;
      end
    end
  endtask

  logic last_if_ack = 1'b0;
  logic last_dm_ack = 1'b0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit busy;
    if (rst) model_reset();
    busy = (m_inflight != 0);
    chk("mem_req",   mem_req,   busy);
    chk("mem_we",    mem_we,    busy ? m_we : 1'b0);
    chk("mem_addr",  mem_addr,  busy ? m_addr : '0);
    chk("mem_wdata", mem_wdata, busy ? m_wdata : '0);
    chk("mem_wmask", mem_wmask, busy ? m_wmask : '0);
    chk("if_ack",    if_ack,    m_acking == 1);
    chk("dm_ack",    dm_ack,    m_acking == 2);
    if (m_acking == 1) chk("if_rdata", if_rdata, m_rdata);
    if (m_acking == 2) chk("dm_rdata", dm_rdata, m_rdata);
    chk("stall_if",  stall_if,  if_req && (m_acking != 1));
    chk("stall_mem", stall_mem, dm_req && (m_acking != 2));
    chk("err",       err,       m_err);
    last_if_ack = if_ack;
    last_dm_ack = dm_ack;
    if (!rst) model_step();
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int if_at, dm_at;
    logic [8:0]  v4_mr, v4_ack, v4_st;
    logic [19:0] v5_mr, v5_ack, v5_err;

    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0; mem_rdata = '0;
    rst = 1'b1;
    repeat (2) sample();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_acks", {if_ack, dm_ack}, 2'b00);
    cyc_start(); rst = 1'b0;
    cyc_start();

    // Scenario 1: single fetch, memory ready at cycle 1.
    cyc_start(); if_req = 1; if_addr = 32'h0000_0040; mem_ready = 0;
    sample(); chk("t1_stall_c0", stall_if, 1'b1); chk("t1_memreq_c0", mem_req, 1'b0);
    cyc_start(); mem_ready = 1; mem_rdata = 32'h0000_0013;
    sample(); chk("t1_memreq_c1", mem_req, 1'b1); chk("t1_addr", mem_addr, 32'h40);
    chk("t1_we", mem_we, 1'b0); chk("t1_stall_c1", stall_if, 1'b1);
    cyc_start(); mem_ready = 0;
    sample(); chk("t1_ack", if_ack, 1'b1); chk("t1_rdata", if_rdata, 32'h13);
    chk("t1_stall_c2", stall_if, 1'b0);
    cyc_start(); if_req = 0;
    sample(); chk("t1_ack_c3", if_ack, 1'b0);

    // Scenario 3: store, then a single ack with zero data.
    cyc_start(); dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wmask = 4'hF;
    sample();
    cyc_start(); mem_ready = 1; mem_rdata = 32'h55AA_55AA;
    sample(); chk("t3_we", mem_we, 1'b1); chk("t3_addr", mem_addr, 32'h100);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF); chk("t3_wmask", mem_wmask, 4'hF);
    cyc_start(); mem_ready = 0;
    sample(); chk("t3_ack", dm_ack, 1'b1); chk("t3_rdata", dm_rdata, 32'h0);
    chk("t3_if_ack", if_ack, 1'b0);
    cyc_start(); dm_req = 0; dm_we = 0;
    sample(); chk("t3_ack_c3", dm_ack, 1'b0);

    // Scenario 2: simultaneous requests with an always-ready memory (last grant was data).
    if_at = -1; dm_at = -1;
    cyc_start(); if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    mem_ready = 1; mem_rdata = 32'hA5;
    sample();
    for (int t = 1; t <= 7; t++) begin
      cyc_start();
      if (if_at == t - 1) if_req = 0;
      if (dm_at == t - 1) dm_req = 0;
      sample();
      if (if_ack && if_at < 0) if_at = t;
      if (dm_ack && dm_at < 0) dm_at = t;
    end
    chk("t2_if_ack_cycle", if_at, FAIR ? 2 : 5);
    chk("t2_dm_ack_cycle", dm_at, FAIR ? 5 : 2);
    cyc_start(); mem_ready = 0;

    // Scenario 4: memory 5 cycles late.
    for (int t = 0; t <= 8; t++) begin
      cyc_start();
      if (t == 0) begin if_req = 1; if_addr = 32'h44; end
      if (t == 8) if_req = 0;
      mem_ready = (t == 6); mem_rdata = 32'h1234;
      sample();
      v4_mr[t] = mem_req; v4_ack[t] = if_ack; v4_st[t] = stall_if;
    end
    chk("t4_mem_req_cycles", v4_mr, 9'h07E);
    chk("t4_ack_cycles", v4_ack, 9'h080);
    chk("t4_stall_cycles", v4_st, 9'h07F);

    // Scenario 5: memory never answers; watchdog aborts.
    for (int t = 0; t <= 19; t++) begin
      cyc_start();
      if (t == 0) begin if_req = 1; if_addr = 32'h48; end
      if (t == 18) if_req = 0;
      mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
      sample();
      v5_mr[t] = mem_req; v5_ack[t] = if_ack; v5_err[t] = err;
      if (if_ack) chk("t5_rdata", if_rdata, 32'h0);
    end
    chk("t5_mem_req_cycles", v5_mr, 20'h1_FFFE);
    chk("t5_ack_cycles", v5_ack, 20'h2_0000);
    chk("t5_err_cycles", v5_err, 20'hE_0000);

    // Scenario 6: reset in the middle of a data access, then a normal fetch.
    cyc_start(); dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    sample();
    for (int t = 1; t <= 2; t++) begin cyc_start(); sample(); end
    cyc_start();
    chk("t6_busy_before_rst", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_mem_req", mem_req, 1'b0);
    chk("t6_rst_dm_ack", dm_ack, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    dm_req = 0;
    sample();
    cyc_start(); rst = 1'b0;
    cyc_start(); if_req = 1; if_addr = 32'h4C; mem_ready = 1; mem_rdata = 32'h77;
    sample();
    cyc_start(); sample(); chk("t6_next_busy", mem_req, 1'b1);
    cyc_start(); sample(); chk("t6_next_ack", if_ack, 1'b1); chk("t6_next_rdata", if_rdata, 32'h77);
    cyc_start(); if_req = 0; mem_ready = 0;
    sample();

    // Random traffic; protocol: hold req until ack, drop it on the following cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc_start();
      if (last_if_ack) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (last_dm_ack) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom();
        dm_wdata = $urandom(); dm_wmask = 4'($urandom_range(0, 15));
      end
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom();
    end
    cyc_start(); if_req = 0; dm_req = 0; mem_ready = 0;
    repeat (3) sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
